// File: rtl/qam_mapper_if.sv
// Bit-stream in / I-Q out handshake bundle for the OFDM constellation mapper.
// The source side (bit producer and I/Q consumer) uses master; the mapper uses slave.
interface qam_mapper_if #(
    parameter int DATA_W = 8
);
    logic                     map_din;
    logic                     map_din_vld;
    logic                     map_din_rdy;
    logic [1:0]               map_din_Map_Type;
    logic signed [DATA_W-1:0] map_dout_I;
    logic signed [DATA_W-1:0] map_dout_Q;
    logic                     map_dout_vld;
    logic                     map_dout_rdy;
    logic                     map_dout_last;

    modport master (
        output map_din,
        output map_din_vld,
        output map_din_Map_Type,
        output map_dout_rdy,
        input  map_din_rdy,
        input  map_dout_I,
        input  map_dout_Q,
        input  map_dout_vld,
        input  map_dout_last
    );

    modport slave (
        input  map_din,
        input  map_din_vld,
        input  map_din_Map_Type,
        input  map_dout_rdy,
        output map_din_rdy,
        output map_dout_I,
        output map_dout_Q,
        output map_dout_vld,
        output map_dout_last
    );
endinterface

// File: rtl/qam_mapper.sv
// Serial-bit to BPSK/QPSK/16QAM/64QAM constellation mapper with Q1.6 I/Q output
// and a 48-subcarrier counter flagging the last data subcarrier of each OFDM symbol.
module qam_mapper (
    input  logic         clk,
    input  logic         rst_n,
    qam_mapper_if.slave  map_if
);

    localparam int         DATA_W  = 8;
    localparam logic [5:0] LAST_SC = 6'd47;

    typedef enum logic [1:0] {
        MT_BPSK  = 2'b00,
        MT_QPSK  = 2'b01,
        MT_QAM16 = 2'b10,
        MT_QAM64 = 2'b11
    } map_type_e;

    function automatic logic [2:0] bits_per_sym(input map_type_e t);
        logic [2:0] n;
        case (t)
            MT_BPSK:  n = 3'd1;
            MT_QPSK:  n = 3'd2;
            MT_QAM16: n = 3'd4;
            default:  n = 3'd6;
        endcase
        return n;
    endfunction

    // Gray-coded 4-level amplitude, first bit of the pair is the MSB.
    function automatic logic signed [DATA_W-1:0] level_qam16(input logic [1:0] g);
        logic signed [DATA_W-1:0] v;
        case (g)
            2'b00:   v = -8'sd61;
            2'b01:   v = -8'sd20;
            2'b11:   v =  8'sd20;
            default: v =  8'sd61;
        endcase
        return v;
    endfunction

    function automatic logic signed [DATA_W-1:0] level_qam64(input logic [2:0] g);
        logic signed [DATA_W-1:0] v;
        case (g)
            3'b000:  v = -8'sd69;
            3'b001:  v = -8'sd49;
            3'b011:  v = -8'sd30;
            3'b010:  v = -8'sd10;
            3'b110:  v =  8'sd10;
            3'b111:  v =  8'sd30;
            3'b101:  v =  8'sd49;
            default: v =  8'sd69;
        endcase
        return v;
    endfunction

    // b holds the subcarrier bits with b0 in the most significant used position.
    function automatic logic [2*DATA_W-1:0] map_symbol(input map_type_e t, input logic [5:0] b);
        logic signed [DATA_W-1:0] i_v;
        logic signed [DATA_W-1:0] q_v;
        case (t)
            MT_BPSK: begin
                i_v = b[0] ? 8'sd64 : -8'sd64;
                q_v = '0;
            end
            MT_QPSK: begin
                i_v = b[1] ? 8'sd45 : -8'sd45;
                q_v = b[0] ? 8'sd45 : -8'sd45;
            end
            MT_QAM16: begin
                i_v = level_qam16(b[3:2]);
                q_v = level_qam16(b[1:0]);
            end
            default: begin
                i_v = level_qam64(b[5:3]);
                q_v = level_qam64(b[2:0]);
            end
        endcase
        return {i_v, q_v};
    endfunction

    logic [2:0]               bit_cnt_q, bit_cnt_d;
    map_type_e                type_q, type_d;
    logic [4:0]               shift_q, shift_d;
    logic [5:0]               sc_cnt_q, sc_cnt_d;
    logic signed [DATA_W-1:0] i_q, i_d;
    logic signed [DATA_W-1:0] q_q, q_d;
    logic                     vld_q, vld_d;
    logic                     last_q, last_d;

    map_type_e                cur_type;
    logic [2:0]               n_bits;
    logic                     final_bit;
    logic                     din_rdy;
    logic                     din_acc;
    logic                     out_load;
    logic                     out_take;
    logic [5:0]               sym_bits;
    logic signed [DATA_W-1:0] i_sym, q_sym;

    // Modulation is taken live from the port on b0 and from the held copy afterwards.
    assign cur_type  = (bit_cnt_q == 3'd0) ? map_type_e'(map_if.map_din_Map_Type) : type_q;
    assign n_bits    = bits_per_sym(cur_type);
    assign final_bit = (bit_cnt_q == n_bits - 3'd1);
    assign din_rdy   = !final_bit || !vld_q || map_if.map_dout_rdy;
    assign din_acc   = map_if.map_din_vld && din_rdy;
    assign out_load  = din_acc && final_bit;
    assign out_take  = vld_q && map_if.map_dout_rdy;
    assign sym_bits  = {shift_q, map_if.map_din};
    assign {i_sym, q_sym} = map_symbol(cur_type, sym_bits);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        type_d    = type_q;
        shift_d   = shift_q;
        sc_cnt_d  = sc_cnt_q;
        i_d       = i_q;
        q_d       = q_q;
        vld_d     = vld_q;
        last_d    = last_q;

        if (din_acc) begin
            if (bit_cnt_q == 3'd0) begin
                type_d = map_type_e'(map_if.map_din_Map_Type);
            end
            if (final_bit) begin
                bit_cnt_d = 3'd0;
                shift_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = sym_bits[4:0];
            end
        end

        // A new final bit on a consume edge keeps vld high with fresh data.
        if (out_load) begin
            i_d      = i_sym;
            q_d      = q_sym;
            vld_d    = 1'b1;
            last_d   = (sc_cnt_q == LAST_SC);
            sc_cnt_d = (sc_cnt_q == LAST_SC) ? 6'd0 : sc_cnt_q + 6'd1;
        end else if (out_take) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 3'd0;
            type_q    <= MT_BPSK;
            shift_q   <= '0;
            sc_cnt_q  <= 6'd0;
            i_q       <= '0;
            q_q       <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            type_q    <= type_d;
            shift_q   <= shift_d;
            sc_cnt_q  <= sc_cnt_d;
            i_q       <= i_d;
            q_q       <= q_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    assign map_if.map_din_rdy   = din_rdy;
    assign map_if.map_dout_I    = i_q;
    assign map_if.map_dout_Q    = q_q;
    assign map_if.map_dout_vld  = vld_q;
    assign map_if.map_dout_last = last_q;

endmodule
